// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: FSM state encoding,
// display-select codes and the default stopwatch mode value.
package stopwatch_pkg;

    // FSM states; the encoding is exported on run_state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_e;

    // show_mode codes presented to the display path.
    localparam logic [1:0] SHOW_LIVE  = 2'd0;
    localparam logic [1:0] SHOW_LAP   = 2'd1;
    localparam logic [1:0] SHOW_PAUSE = 2'd2;

    // currentMode value that hands button ownership to the stopwatch.
    localparam logic [1:0] MODE_SW_DEFAULT = 2'd2;

    // Display select for a given state: only LAP freezes and only PAUSE shows paused.
    function automatic logic [1:0] show_code(input sw_state_e s);
        logic [1:0] code;
        case (s)
            LAP:     code = SHOW_LAP;
            PAUSE:   code = SHOW_PAUSE;
            default: code = SHOW_LIVE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stopwatch_control_sw_button_edge.sv
// Button front end: 2-flop synchroniser, optional debouncer, rising-edge pulse.
// The debouncer is compiled in with `define STOPWATCH_DEBOUNCE_EN.
// btn_rise is a combinational AND of flops so the FSM sees the event on the
// 3rd clock edge after the raw input rises (plus DEBOUNCE_CYCLES when enabled).
module sw_button_edge #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level_s;

    // Synchroniser and edge-history next values.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level_s;
    end

    // Synchroniser and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised level differs from the
    // debounced level; adopt it once it has been stable long enough.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_s = deb_q;
`else
    // Debounce length only matters when the debouncer is built in.
    logic unused_deb_cfg_s;
    assign unused_deb_cfg_s = ^DEBOUNCE_CYCLES;
    assign level_s          = sync2_q;
`endif

    assign btn_rise = level_s & ~prev_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control FSM: turns start/stop and lap/clear button events into
// the count tick, clear and lap-latch strobes and the display select.
// Optional input debouncing is enabled with `define STOPWATCH_DEBOUNCE_EN.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int         TICK_DIV        = 10,
    parameter logic [1:0] MODE_SW         = MODE_SW_DEFAULT,
    parameter int         DEBOUNCE_CYCLES = 20
) (
    input  logic       mili_clk,
    input  logic       reset,
    input  logic [1:0] currentMode,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       sw_full,
    output logic       tick,
    output logic       clear_pulse,
    output logic       lap_latch,
    output logic [1:0] show_mode,
    output logic [1:0] run_state
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic start_ev_s, lap_ev_s;
    logic start_s, lap_s;

    sw_button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk      (mili_clk),
        .rst_n    (reset),
        .btn_raw  (btn_start),
        .btn_rise (start_ev_s)
    );

    sw_button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk      (mili_clk),
        .rst_n    (reset),
        .btn_raw  (btn_lap),
        .btn_rise (lap_ev_s)
    );

    // Drop events when another mode owns the buttons; start beats lap.
    always_comb begin
        start_s = start_ev_s & (currentMode == MODE_SW);
        lap_s   = lap_ev_s & (currentMode == MODE_SW) & ~start_s;
    end

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d, presc_nxt_s;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          latch_q, latch_d;
    logic [1:0]    show_q, show_d;
    logic          counting_s;

    // Next state, strobes and prescaler; strobes land with the new state.
    always_comb begin
        state_d     = state_q;
        clear_d     = 1'b0;
        latch_d     = 1'b0;
        tick_d      = 1'b0;
        presc_nxt_s = presc_q;
        counting_s  = (state_q == RUN) || (state_q == LAP);

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = RUN;
                end else if (lap_s) begin
                    clear_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (sw_full || start_s) begin
                    state_d = PAUSE;
                end else if (lap_s) begin
                    state_d = LAP;
                    latch_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            LAP: begin
                if (sw_full || start_s) begin
                    state_d = PAUSE;
                end else if (lap_s) begin
                    state_d = RUN;
                end else begin
                    state_d = LAP;
                end
            end
            PAUSE: begin
                // A full datapath can only be left through clear.
                if (start_s && !sw_full) begin
                    state_d = RUN;
                end else if (lap_s) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Prescaler advances only while counting and not saturated.
        if (counting_s && !sw_full) begin
            if (presc_q == PRESC_MAX) begin
                presc_nxt_s = '0;
                tick_d      = 1'b1;
            end else begin
                presc_nxt_s = presc_q + PW'(1);
            end
        end else begin
            presc_nxt_s = presc_q;
        end

        presc_d = (state_d == IDLE) ? '0 : presc_nxt_s;
        show_d  = show_code(state_d);
    end

    // FSM, prescaler and registered outputs.
    always_ff @(posedge mili_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            latch_q <= 1'b0;
            show_q  <= SHOW_LIVE;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            latch_q <= latch_d;
            show_q  <= show_d;
        end
    end

    assign tick        = tick_q;
    assign clear_pulse = clear_q;
    assign lap_latch   = latch_q;
    assign show_mode   = show_q;
    assign run_state   = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control: expected events (with the clock
// cycle they must appear on) are queued up front; a negedge monitor pops and
// compares whenever the DUT shows a tick, a strobe or a state change.
module tb_stopwatch_control;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int LAT   = 3 + 20;
    localparam int PRESS = 25;
`else
    localparam int LAT   = 3;
    localparam int PRESS = 5;
`endif

    logic       mili_clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] currentMode = 2'd2;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       sw_full = 1'b0;
    logic       tick, clear_pulse, lap_latch;
    logic [1:0] show_mode, run_state;

    stopwatch_control dut (
        .mili_clk    (mili_clk),
        .reset       (reset),
        .currentMode (currentMode),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .sw_full     (sw_full),
        .tick        (tick),
        .clear_pulse (clear_pulse),
        .lap_latch   (lap_latch),
        .show_mode   (show_mode),
        .run_state   (run_state)
    );

    always #5 mili_clk = ~mili_clk;

    int cyc = 0;
    always @(posedge mili_clk) cyc <= cyc + 1;

    typedef struct { int c; int rs; int sm; } st_exp_t;
    typedef struct { int c; int clr; int lat; } sb_exp_t;
    st_exp_t st_q[$];
    sb_exp_t sb_q[$];
    int      tick_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic [1:0] prev_rs = 2'd0;
    logic [1:0] prev_sm = 2'd0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_st(input int c, input int rs, input int sm);
        st_exp_t e;
        e.c = c; e.rs = rs; e.sm = sm;
        st_q.push_back(e);
    endtask

    task automatic push_sb(input int c, input int clr, input int lat);
        sb_exp_t e;
        e.c = c; e.clr = clr; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic push_ticks(input int first, input int last);
        for (int t = first; t <= last; t += 10) tick_q.push_back(t);
    endtask

    task automatic at_cyc(input int n);
        @(negedge mili_clk);
        while (cyc < n) @(negedge mili_clk);
    endtask

    task automatic press_len(input int pc, input logic s, input logic l, input int len);
        at_cyc(pc);
        btn_start = s;
        btn_lap   = l;
        repeat (len) @(negedge mili_clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_clear_pulse"}, int'(clear_pulse), 0);
        check({tag, "_lap_latch"}, int'(lap_latch), 0);
        check({tag, "_show_mode"}, int'(show_mode), 0);
        check({tag, "_run_state"}, int'(run_state), 0);
    endtask

    // Monitor: every visible DUT event consumes the matching expectation.
    always @(negedge mili_clk) begin
        if (mon_en) begin
            if (tick) begin
                if (tick_q.size() == 0) check("tick_unexpected_cycle", cyc, -1);
                else check("tick_cycle", cyc, tick_q.pop_front());
            end
            if (clear_pulse || lap_latch) begin
                if (sb_q.size() == 0) begin
                    check("strobe_unexpected_cycle", cyc, -1);
                end else begin
                    sb_exp_t e;
                    e = sb_q.pop_front();
                    check("strobe_cycle", cyc, e.c);
                    check("clear_pulse", int'(clear_pulse), e.clr);
                    check("lap_latch", int'(lap_latch), e.lat);
                end
            end
            if (run_state != prev_rs || show_mode != prev_sm) begin
                if (st_q.size() == 0) begin
                    check("state_change_unexpected_cycle", cyc, -1);
                end else begin
                    st_exp_t e;
                    e = st_q.pop_front();
                    check("state_cycle", cyc, e.c);
                    check("run_state", int'(run_state), e.rs);
                    check("show_mode", int'(show_mode), e.sm);
                end
            end
        end
        prev_rs <= run_state;
        prev_sm <= show_mode;
    end

    initial begin
        int t0;
        int r;
        #1 reset = 1'b0;
        #1 check_reset_outputs("por");
        at_cyc(5);
        reset = 1'b1;
        @(negedge mili_clk);
        mon_en = 1'b1;

        // Button presses happen at cycle 20+offset; events land at t0+offset.
        t0 = 20 + LAT;
        push_st(t0,       1, 0);
        push_st(t0 + 55,  2, 1);
        push_st(t0 + 105, 1, 0);
        push_st(t0 + 154, 3, 2);
        push_st(t0 + 204, 1, 0);
        push_st(t0 + 254, 3, 2);
        push_st(t0 + 304, 0, 0);
        push_st(t0 + 404, 1, 0);
        push_st(t0 + 457, 3, 2);
        push_st(t0 + 507, 1, 0);
        push_st(t0 + 614, 3, 2);
        push_st(t0 + 710, 0, 0);
        push_st(t0 + 760, 1, 0);
        push_sb(t0 + 55,  0, 1);
        push_sb(t0 + 304, 1, 0);
        push_sb(t0 + 354, 1, 0);
        push_sb(t0 + 710, 1, 0);
        push_ticks(t0 + 10,  t0 + 150);
        push_ticks(t0 + 210, t0 + 250);
        push_ticks(t0 + 414, t0 + 454);
        push_ticks(t0 + 514, t0 + 604);
        push_ticks(t0 + 770, t0 + 780);

        press_len(20,  1'b1, 1'b0, PRESS);   // IDLE -> RUN
        press_len(75,  1'b0, 1'b1, PRESS);   // RUN -> LAP, lap_latch
        press_len(125, 1'b0, 1'b1, PRESS);   // LAP -> RUN
        press_len(174, 1'b1, 1'b0, PRESS);   // RUN -> PAUSE, prescaler held at 4
        press_len(224, 1'b1, 1'b0, PRESS);   // PAUSE -> RUN, tick 6 cycles later
        press_len(274, 1'b1, 1'b0, PRESS);   // RUN -> PAUSE
        press_len(324, 1'b0, 1'b1, PRESS);   // PAUSE -> IDLE, clear
        press_len(374, 1'b0, 1'b1, PRESS);   // IDLE clear only
        press_len(424, 1'b1, 1'b0, PRESS);   // IDLE -> RUN
        press_len(477, 1'b1, 1'b1, PRESS);   // both: start wins -> PAUSE
        press_len(527, 1'b1, 1'b0, PRESS);   // PAUSE -> RUN (held 3)
        at_cyc(575);
        currentMode = 2'd0;
        press_len(577, 1'b1, 1'b1, PRESS);   // ignored in other mode
        at_cyc(t0 + 562);
        currentMode = 2'd2;
        at_cyc(t0 + 613);
        sw_full = 1'b1;                      // full on the would-be tick edge
        press_len(680, 1'b1, 1'b0, PRESS);   // start ignored while full
        press_len(730, 1'b0, 1'b1, PRESS);   // clear leaves full pause
        at_cyc(t0 + 720);
        sw_full = 1'b0;
        press_len(780, 1'b1, 1'b0, PRESS);   // IDLE -> RUN

        // Asynchronous reset between clock edges while running.
        at_cyc(t0 + 785);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        at_cyc(t0 + 790);
        reset = 1'b1;
        @(negedge mili_clk);
        mon_en = 1'b1;

`ifdef STOPWATCH_DEBOUNCE_EN
        press_len(t0 + 800, 1'b1, 1'b0, 15); // short glitch: no event
`endif
        r = t0 + 880 + LAT;
        push_st(r, 1, 0);
        push_ticks(r + 10, r + 20);          // prescaler restarted from 0
        press_len(t0 + 880, 1'b1, 1'b0, PRESS);
        at_cyc(r + 25);

        check("pending_state_events", st_q.size(), 0);
        check("pending_strobe_events", sb_q.size(), 0);
        check("pending_tick_events", tick_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
